// File: rtl/uart_tx_if.sv
// Byte write channel into the UART transmitter FIFO.
`timescale 1ns/1ps
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO, paced by an external baud
// square wave that is synchronized and edge-detected into a one-cycle tick.
`timescale 1ns/1ps
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_baud_clk,
  uart_tx_if.slave  bus,
  output logic      o_tx,
  output logic      o_busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_sync1, r_sync2, r_baud_prev;
  logic                 w_tick;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 w_push, w_pop, w_fifo_nempty;

  // BaudClk is asynchronous data: two flops for metastability, a third for edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_baud_prev <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_sync1     <= i_baud_clk;
      r_sync2     <= r_sync1;
      r_baud_prev <= r_sync2;
    end
  end

  assign w_tick        = r_sync2 & ~r_baud_prev;
  assign w_fifo_nempty = (r_count != '0);
  assign bus.ready     = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push        = bus.valid & bus.ready;

  // NOTE: the storage array carries no reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_pop         = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE, S_STOP: begin
          if (w_fifo_nempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_START: begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end
        S_DATA: begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'(DATA_BITS - 1)) w_state_nxt = S_STOP;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // Tx is registered from the next-state view so it moves one cycle after the tick.
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = (r_state != S_IDLE) || w_fifo_nempty;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: BaudClk period of 8 clk, frames sampled every
// cycle so both bit values and exact bit lengths are checked.
`timescale 1ns/1ps
module tb_uart_tx;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic baud  = 1'b0;
  logic tx, busy;

  uart_tx_if #(.DATA_BITS(8)) bus ();

  uart_tx #(.FIFO_DEPTH(4), .DATA_BITS(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_baud_clk (baud),
    .bus        (bus),
    .o_tx       (tx),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;

  bit baud_run    = 1'b0;
  bit baud_freeze = 1'b0;
  int baud_cnt    = 0;

  logic [7:0] pend_b = '0;
  bit         pend = 1'b0, pend_clr = 1'b0;

  logic [7:0] rx_byte;
  logic       rx_start, rx_stop, rx_stable, rx_ready0, rx_busy79;
  bit         rx_timeout;
  int         rx_t0, rx_cnt0, rx_cnt79;

  initial forever begin
    @(posedge clk);
    ncyc++;
  end

  // Baud square wave: toggles every 4 clk on the falling clk edge; can be parked low.
  initial forever begin
    @(negedge clk);
    if (baud_run) begin
      if (baud_freeze && !baud) begin
        baud_run = 1'b0;
      end else begin
        baud_cnt++;
        if (baud_cnt == 4) begin
          baud_cnt = 0;
          baud     = ~baud;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of run, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.data  = b;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_start_seen"}, found, 1);
  endtask

  task automatic freeze_baud(input string tag);
    bit done = 1'b0;
    baud_freeze = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!baud_run) begin
        done = 1'b1;
        break;
      end
    end
    baud_freeze = 1'b0;
    check({tag, "_frozen"}, done, 1);
  endtask

  // Waits for a start bit, then samples all 80 cycles of the frame.
  task automatic recv_frame();
    logic [9:0] bits = '0;
    bit found = 1'b0;
    rx_stable = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (pend_clr) begin
        bus.valid = 1'b0;
        pend_clr  = 1'b0;
      end
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    rx_timeout = !found;
    rx_t0      = ncyc;
    rx_ready0  = bus.ready;
    rx_cnt0    = int'(u_dut.r_count);
    if (found) begin
      for (int t = 0; t < 80; t++) begin
        if (t > 0) @(negedge clk);
        if (t % 8 == 0) bits[t/8] = tx;
        else if (tx !== bits[t/8]) rx_stable = 1'b0;
        if (t == 79) begin
          rx_busy79 = busy;
          rx_cnt79  = int'(u_dut.r_count);
          if (pend) begin
            bus.data  = pend_b;
            bus.valid = 1'b1;
            pend      = 1'b0;
            pend_clr  = 1'b1;
          end
        end
      end
    end
    rx_start = bits[0];
    rx_byte  = bits[8:1];
    rx_stop  = bits[9];
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b);
    check({tag, "_timeout"}, rx_timeout, 0);
    check({tag, "_startbit"}, rx_start, 0);
    check({tag, "_byte"}, rx_byte, b);
    check({tag, "_stopbit"}, rx_stop, 1);
    check({tag, "_bitlen8"}, rx_stable, 1);
  endtask

  initial begin
    int t1, errs, t, k, seg, len;
    bit ok, ended;
    logic lvl, exp_tx;

    bus.data  = '0;
    bus.valid = 1'b0;
    baud_run  = 1'b1;

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.ready, 1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);

    // Single 0x55 frame; Busy drops right after the stop bit
    push(8'h55);
    recv_frame();
    check_frame("f55", 8'h55);
    check("f55_busy_in_stop", rx_busy79, 1);
    @(negedge clk);
    check("f55_busy_fall", busy, 0);

    // 0xA3 then 0x0F on consecutive cycles: back-to-back frames
    @(negedge clk);
    bus.data  = 8'hA3;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.data  = 8'h0F;
    @(negedge clk);
    bus.valid = 1'b0;
    recv_frame();
    check_frame("fA3", 8'hA3);
    t1 = rx_t0;
    recv_frame();
    check_frame("f0F", 8'h0F);
    check("b2b_gap", rx_t0 - t1, 80);
    @(negedge clk);
    check("b2b_busy_fall", busy, 0);
    check("b2b_total", ncyc - t1, 160);

    // FIFO full with the baud parked: four writes accepted, fifth dropped
    freeze_baud("full");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_ready_before_write", bus.ready, (i < 4));
      bus.data  = 8'((i + 1) * 17);
      bus.valid = 1'b1;
    end
    @(negedge clk);
    bus.valid = 1'b0;
    check("full_ready_low", bus.ready, 0);
    check("full_busy", busy, 1);
    errs = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.ready !== 1'b0 || tx !== 1'b1) errs++;
    end
    check("full_stalled", errs, 0);
    baud_run = 1'b1;
    recv_frame();
    check("full_ready_after_pop", rx_ready0, 1);
    check_frame("full0", 8'h11);
    for (int i = 1; i < 4; i++) begin
      recv_frame();
      check_frame("fullN", 8'((i + 1) * 17));
    end
    @(negedge clk);
    check("full_fifth_dropped", busy, 0);

    // Push coinciding with the pop at count=2
    @(negedge clk);
    bus.data  = 8'h12;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.data  = 8'h34;
    @(negedge clk);
    bus.data  = 8'h56;
    @(negedge clk);
    bus.valid = 1'b0;
    pend_b = 8'h78;
    pend   = 1'b1;
    recv_frame();
    check_frame("pp12", 8'h12);
    check("pp_count_before", rx_cnt79, 2);
    recv_frame();
    check("pp_count_after", rx_cnt0, 2);
    check_frame("pp34", 8'h34);
    recv_frame();
    check_frame("pp56", 8'h56);
    recv_frame();
    check_frame("pp78", 8'h78);
    @(negedge clk);
    check("pp_busy_fall", busy, 0);

    // Reset during data bit 3 of 0xFF with two bytes queued
    @(negedge clk);
    bus.data  = 8'hFF;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.data  = 8'h01;
    @(negedge clk);
    bus.data  = 8'h02;
    @(negedge clk);
    bus.valid = 1'b0;
    wait_start("rstmid");
    repeat (36) @(negedge clk);
    check("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", bus.ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("rstmid_no_more_frames", errs, 0);

    // BaudClk held low for 1000 cycles mid-frame
    push(8'h55);
    wait_start("stall");
    t1 = ncyc;
    repeat (20) @(negedge clk);
    freeze_baud("stall");
    t      = ncyc - t1;
    k      = t / 8;
    exp_tx = fbit(8'h55, k);
    check("stall_tx_at_freeze", tx, exp_tx);
    errs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== exp_tx || busy !== 1'b1) errs++;
    end
    check("stall_hold", errs, 0);
    baud_run = 1'b1;
    lvl   = tx;
    seg   = 0;
    len   = 0;
    ok    = 1'b1;
    ended = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ended = 1'b1;
        break;
      end
      if (tx !== lvl) begin
        if (seg > 0 && len != 8) ok = 1'b0;
        seg++;
        lvl = tx;
        if (lvl !== fbit(8'h55, k + seg)) ok = 1'b0;
        len = 1;
      end else begin
        len++;
      end
    end
    if (seg > 0 && len != 8) ok = 1'b0;
    check("stall_resume_done", ended, 1);
    check("stall_resume_bits", seg, 9 - k);
    check("stall_resume_shape", ok, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: byte FIFO entries, power of 2, range 2..16.
REQ-002 Parameter DATA_BITS, default 8: payload bits per frame, fixed at 8 for this release.
REQ-003 Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; takes effect immediately, released synchronously to Clk.
REQ-005 BaudClk  input  1  baud-rate square wave from the baud generator (ClkOut); one rising edge per bit time; sampled as data, never used as a clock.
REQ-006 Data  input  8  byte to transmit, valid when DataValid=1.
REQ-007 DataValid  input  1  Data write request.
REQ-008 Ready  output  1  FIFO can accept a byte this cycle.
REQ-009 Tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-010 Busy  output  1  high while a frame is in flight or the FIFO is non-empty.

Function
REQ-011 BaudClk SHALL pass through a 2-flop synchronizer; a rising-edge detector on the synchronized value SHALL produce a one-Clk-cycle Tick.
REQ-012 Tick SHALL assert 3 Clk cycles after the first Clk edge that samples BaudClk high.
REQ-013 Ready SHALL equal (count != FIFO_DEPTH), combinational from registered count only.
REQ-014 A write SHALL occur when DataValid && Ready; the byte is visible in the FIFO the next cycle; DataValid while Ready=0 SHALL be ignored and the byte dropped.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 FSM states: IDLE, START, DATA, STOP; bit index 3 bits, range 0..7.
REQ-017 IDLE: Tx=1; on Tick with count!=0, pop the head byte into a shift register and enter START.
REQ-018 START: Tx=0; on Tick enter DATA, bit index=0.
REQ-019 DATA: Tx=shift[0]; on Tick shift right and increment index; on Tick with index=7 enter STOP.
REQ-020 STOP: Tx=1; on Tick with count!=0, pop and enter START (back-to-back frames, no idle gap); on Tick with count=0, enter IDLE.
REQ-021 Tx SHALL be registered and change only in the Clk cycle after Tick; each bit SHALL last exactly one BaudClk period (2*(MAX_CNT+1) Clk cycles, 694 at 80 MHz/115200).
REQ-022 Frame length SHALL be 10 bit times; the FIFO pop SHALL occur in the same cycle as the STOP->START or IDLE->START transition.
REQ-023 Busy SHALL equal (state != IDLE) || (count != 0), registered-source only.
REQ-024 Writes SHALL be accepted in every state, including mid-frame; they never disturb the frame in flight.
REQ-025 Without Tick the FSM SHALL hold state indefinitely (BaudClk stuck produces no progress and no glitch on Tx).

Reset
REQ-026 On Reset=0: Tx=1, Busy=0, Ready=1, state=IDLE, count=0, pointers=0, bit index=0, shift register=0, both synchronizer flops and the edge-history flop=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (Tx=1 in the same instant) and discard all FIFO contents.
REQ-028 If BaudClk is high when Reset releases, one Tick SHALL occur 3 cycles later; this is permitted and is not an error.

Verification
REQ-029 BaudClk period 8 Clk; write 0x55 once -> Tx: 0, then 1,0,1,0,1,0,1,0, then 1; each bit 8 cycles; Busy falls after the stop bit completes.
REQ-030 Write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back, stop bit of the first immediately followed by start bit of the second, 160 Clk total from the first start edge.
REQ-031 Hold DataValid=1 with frames not draining -> Ready=0 after exactly FIFO_DEPTH=4 writes; the 5th byte is dropped; Ready=1 the cycle after the first pop.
REQ-032 Push and pop in the same cycle at count=2 -> count stays 2; byte order preserved on Tx.
REQ-033 Assert Reset during DATA bit 3 of 0xFF with 2 bytes queued -> Tx=1 immediately, Busy=0; after release, no further frames are sent.
REQ-034 Hold BaudClk low for 1000 cycles mid-frame -> Tx constant, state unchanged; the frame resumes correctly on the next edge.
